// File: rtl/spi_pkg.sv
// Shared SPI frame definitions used by the frame controller and the peripheral side.
// Frame layout is {word0, word1, word2}, MSB of word0 transmitted first.
package spi_pkg;

  localparam int FRAME_W   = 48;
  localparam int WORD_W    = 16;
  localparam int N_WORDS   = 3;
  localparam int BIT_CNT_W = 6;

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = 6'd47;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } spi_state_t;

  // Counter width for a terminal count of n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_sclk_divider.sv
// Generates the idle-low SPI clock from clk while run is high, with one-cycle
// rise/fall strobes asserted in the cycle whose closing edge updates sclk.
module spi_sclk_divider
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int DIV_W = cnt_width(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             half_done;

  assign half_done = run && (cnt_q == DIV_LAST);
  assign rise      = half_done && !sclk_q;
  assign fall      = half_done && sclk_q;
  assign sclk      = sclk_q;

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!run) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (half_done) begin
      cnt_d  = '0;
      sclk_d = !sclk_q;
    end else begin
      cnt_d  = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_frame_controller.sv
// Mode-0 SPI master sending one 48-bit frame per valid/ready handshake and
// capturing sdi full-duplex; rx_data/rx_valid update when cs_n returns high.
module spi_frame_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tx_valid,
  output logic               tx_ready,
  input  logic [FRAME_W-1:0] tx_data,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  output logic               busy,
  output logic               sclk,
  output logic               sdo,
  input  logic               sdi,
  output logic               cs_n
);

  localparam int WAIT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int WAIT_W   = cnt_width(WAIT_MAX);
  localparam logic [WAIT_W-1:0] SETUP_LAST = WAIT_W'(CS_SETUP - 1);
  localparam logic [WAIT_W-1:0] HOLD_LAST  = WAIT_W'(CS_HOLD - 1);

  spi_state_t           state_q, state_d;
  logic [FRAME_W-1:0]   tx_sr_q, tx_sr_d;
  logic [FRAME_W-1:0]   rx_sr_q, rx_sr_d;
  logic [FRAME_W-1:0]   rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                 cs_n_q, cs_n_d;
  logic                 sdo_q, sdo_d;

  logic shift_run;
  logic sclk_rise;
  logic sclk_fall;

  assign shift_run = (state_q == SHIFT);

  spi_sclk_divider #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_divider (
    .clk  (clk),
    .reset(reset),
    .run  (shift_run),
    .sclk (sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  assign tx_ready = (state_q == IDLE);
  assign busy     = !tx_ready;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign cs_n     = cs_n_q;
  assign sdo      = sdo_q;

  always_comb begin
    state_d    = state_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    bit_cnt_d  = bit_cnt_q;
    wait_cnt_d = wait_cnt_q;
    cs_n_d     = cs_n_q;
    sdo_d      = sdo_q;

    case (state_q)
      IDLE: begin
        cs_n_d = 1'b1;
        sdo_d  = 1'b0;
        if (tx_valid) begin
          state_d    = SETUP;
          tx_sr_d    = tx_data;
          rx_sr_d    = '0;
          bit_cnt_d  = '0;
          wait_cnt_d = '0;
          cs_n_d     = 1'b0;
          sdo_d      = tx_data[FRAME_W-1];
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (wait_cnt_q == SETUP_LAST) begin
          state_d    = SHIFT;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          rx_sr_d = {rx_sr_q[FRAME_W-2:0], sdi};
        end else begin
          rx_sr_d = rx_sr_q;
        end
        // Rotation keeps the register fully used; only the MSB ever reaches sdo.
        if (sclk_fall) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d    = HOLD;
            wait_cnt_d = '0;
          end else begin
            tx_sr_d   = {tx_sr_q[FRAME_W-2:0], tx_sr_q[FRAME_W-1]};
            sdo_d     = tx_sr_q[FRAME_W-2];
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end else begin
          state_d = SHIFT;
        end
      end
      HOLD: begin
        if (wait_cnt_q == HOLD_LAST) begin
          state_d    = IDLE;
          cs_n_d     = 1'b1;
          sdo_d      = 1'b0;
          rx_data_d  = rx_sr_q;
          rx_valid_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
        sdo_d   = 1'b0;
      end
    endcase
  end

  // An aborted frame must not disturb the last good rx_data; an idle reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_valid_q <= 1'b0;
      bit_cnt_q  <= '0;
      wait_cnt_q <= '0;
      cs_n_q     <= 1'b1;
      sdo_q      <= 1'b0;
      if (state_q == IDLE) begin
        rx_data_q <= '0;
      end
    end else begin
      state_q    <= state_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      bit_cnt_q  <= bit_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      cs_n_q     <= cs_n_d;
      sdo_q      <= sdo_d;
    end
  end

endmodule

// File: tb/tb_spi_frame_controller.sv
// Bench for spi_frame_controller: default-timing and minimum-timing instances
// checked each cycle against a phase-based frame model plus literal expectations.
module tb_spi_frame_controller;
  import spi_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]         rst, txv, sdi;
  logic [1:0]         txr, bsy, sck, sdo, csn, rxv;
  logic [FRAME_W-1:0] txd [2];
  logic [FRAME_W-1:0] rxd [2];

  spi_frame_controller #(.CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2)) dut_a (
    .clk(clk), .reset(rst[0]), .tx_valid(txv[0]), .tx_ready(txr[0]), .tx_data(txd[0]),
    .rx_data(rxd[0]), .rx_valid(rxv[0]), .busy(bsy[0]), .sclk(sck[0]), .sdo(sdo[0]),
    .sdi(sdi[0]), .cs_n(csn[0]));

  spi_frame_controller #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1)) dut_b (
    .clk(clk), .reset(rst[1]), .tx_valid(txv[1]), .tx_ready(txr[1]), .tx_data(txd[1]),
    .rx_data(rxd[1]), .rx_valid(rxv[1]), .busy(bsy[1]), .sclk(sck[1]), .sdo(sdo[1]),
    .sdi(sdi[1]), .cs_n(csn[1]));

  int n_tests, n_fail, cyc;

  // Model state: ph = clk cycles since the accept edge (0 = idle).
  int                 ph [2];
  logic [FRAME_W-1:0] frm [2], pat [2], rx_exp [2];
  logic [1:0]         rxv_exp, loop, chk_en;

  // Pin-level observers: receiver, cs_n timing, sclk timing, sdi peripheral.
  logic [1:0]         csn_prev, sck_prev;
  int                 frames [2], hi_run [2], last_gap [2], low_run [2], last_low [2];
  int                 fr_rises [2], last_rises [2], rcv_bits [2], pidx [2];
  int                 rise_ivl [2], last_rise [2], rxv_total [2];
  logic [FRAME_W-1:0] rcv_sr [2], rcv_last [2];

  logic [63:0]        rnd;
  logic [FRAME_W-1:0] d_r, p_r;
  logic               lp_r;
  int                 base, n;

  function automatic int p_div(input int i); return (i == 0) ? 4 : 1; endfunction
  function automatic int p_set(input int i); return (i == 0) ? 2 : 1; endfunction
  function automatic int p_hld(input int i); return (i == 0) ? 2 : 1; endfunction
  function automatic int p_len(input int i);
    return p_set(i) + 2 * FRAME_W * p_div(i) + p_hld(i);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected {cs_n, sclk, sdo, tx_ready, busy, rx_valid} from the frame phase.
  function automatic logic [5:0] exp_ctl(input int i);
    int s = p_set(i);
    int d = p_div(i);
    int p = ph[i];
    int u;
    int b;
    logic sc;
    logic so;
    if (p == 0) return {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, rxv_exp[i]};
    sc = 1'b0;
    so = frm[i][FRAME_W-1];
    if (p > s && p <= s + 2 * FRAME_W * d) begin
      u  = p - s - 1;
      b  = u / (2 * d);
      sc = ((u % (2 * d)) >= d);
      so = frm[i][FRAME_W-1-b];
    end else if (p > s + 2 * FRAME_W * d) begin
      so = frm[i][0];
    end
    return {1'b0, sc, so, 1'b0, 1'b1, rxv_exp[i]};
  endfunction

  task automatic model_step(input int i);
    rxv_exp[i] = 1'b0;
    if (rst[i]) begin
      if (ph[i] == 0) rx_exp[i] = '0;
      ph[i] = 0;
    end else if (ph[i] == 0) begin
      if (txv[i]) begin
        ph[i]  = 1;
        frm[i] = txd[i];
      end
    end else if (ph[i] == p_len(i)) begin
      ph[i]      = 0;
      rxv_exp[i] = 1'b1;
      rx_exp[i]  = loop[i] ? frm[i] : pat[i];
    end else begin
      ph[i]++;
    end
  endtask

  task automatic compare(input int i);
    if (chk_en[i]) begin
      check($sformatf("ctl%0d cyc %0d {cs_n,sclk,sdo,rdy,busy,rxv}", i, cyc),
            {58'd0, csn[i], sck[i], sdo[i], txr[i], bsy[i], rxv[i]}, {58'd0, exp_ctl(i)});
      check($sformatf("rx_data%0d cyc %0d", i, cyc), {16'd0, rxd[i]}, {16'd0, rx_exp[i]});
    end
  endtask

  task automatic monitor(input int i);
    if (csn_prev[i] && !csn[i]) begin
      frames[i]++;
      last_gap[i] = hi_run[i];
      hi_run[i]   = 0;
      low_run[i]  = 0;
      fr_rises[i] = 0;
      rcv_bits[i] = 0;
      pidx[i]     = 0;
    end
    if (!csn[i]) low_run[i]++;
    else hi_run[i]++;
    if (!sck_prev[i] && sck[i]) begin
      fr_rises[i]++;
      rcv_sr[i] = {rcv_sr[i][FRAME_W-2:0], sdo[i]};
      rcv_bits[i]++;
      rise_ivl[i]  = cyc - last_rise[i];
      last_rise[i] = cyc;
    end
    if (sck_prev[i] && !sck[i]) pidx[i]++;
    if (!csn_prev[i] && csn[i]) begin
      last_low[i]   = low_run[i];
      last_rises[i] = fr_rises[i];
      if (rcv_bits[i] == FRAME_W) rcv_last[i] = rcv_sr[i];
    end
    if (rxv[i]) rxv_total[i]++;
    sdi[i]      = loop[i] ? sdo[i] : ((pidx[i] < FRAME_W) ? pat[i][FRAME_W-1-pidx[i]] : 1'b0);
    csn_prev[i] = csn[i];
    sck_prev[i] = sck[i];
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i);
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      compare(i);
      monitor(i);
    end
  endtask

  task automatic wait_busy(input int i);
    int k = 0;
    while (!bsy[i] && k < 20) begin
      tick();
      k++;
    end
    check($sformatf("accept%0d busy", i), {63'd0, bsy[i]}, 64'd1);
  endtask

  task automatic wait_rx(input int i);
    int k = 0;
    while (!rxv[i] && k < 3000) begin
      tick();
      k++;
    end
    check($sformatf("frame%0d rx_valid seen", i), {63'd0, rxv[i]}, 64'd1);
  endtask

  task automatic start_frame(input int i, input logic [FRAME_W-1:0] d,
                             input logic lp, input logic [FRAME_W-1:0] p);
    loop[i] = lp;
    pat[i]  = p;
    txd[i]  = d;
    txv[i]  = 1'b1;
    wait_busy(i);
    txv[i]  = 1'b0;
  endtask

  task automatic send(input int i, input logic [FRAME_W-1:0] d,
                      input logic lp, input logic [FRAME_W-1:0] p);
    start_frame(i, d, lp, p);
    wait_rx(i);
    check($sformatf("frame%0d rx_data", i), {16'd0, rxd[i]}, {16'd0, (lp ? d : p)});
    check($sformatf("frame%0d decoded sdo", i), {16'd0, rcv_last[i]}, {16'd0, d});
    repeat (3) tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    rst = 2'b11; txv = 2'b00; sdi = 2'b00; loop = 2'b11; chk_en = 2'b00; rxv_exp = 2'b00;
    csn_prev = 2'b11; sck_prev = 2'b00;
    for (int i = 0; i < 2; i++) begin
      txd[i] = '0; frm[i] = '0; pat[i] = '0; rx_exp[i] = '0; ph[i] = 0;
      frames[i] = 0; hi_run[i] = 0; last_gap[i] = 0; low_run[i] = 0; last_low[i] = 0;
      fr_rises[i] = 0; last_rises[i] = 0; rcv_bits[i] = 0; pidx[i] = 0;
      rise_ivl[i] = 0; last_rise[i] = 0; rxv_total[i] = 0; rcv_sr[i] = '0; rcv_last[i] = '0;
    end

    repeat (4) tick();
    chk_en = 2'b11;
    tick();
    check("reset cs_n", {63'd0, csn[0]}, 64'd1);
    check("reset sclk", {63'd0, sck[0]}, 64'd0);
    check("reset sdo", {63'd0, sdo[0]}, 64'd0);
    check("reset tx_ready", {63'd0, txr[0]}, 64'd1);
    check("reset rx_valid", {63'd0, rxv[0]}, 64'd0);
    check("reset rx_data", {16'd0, rxd[0]}, 64'd0);
    rst = 2'b00;
    repeat (5) tick();

    rst[0] = 1'b1;
    repeat (3) tick();
    check("idle reset cs_n", {63'd0, csn[0]}, 64'd1);
    check("idle reset sclk", {63'd0, sck[0]}, 64'd0);
    check("idle reset tx_ready", {63'd0, txr[0]}, 64'd1);
    check("idle reset rx_valid", {63'd0, rxv[0]}, 64'd0);
    rst[0] = 1'b0;
    tick();

    // Single frame, loopback.
    base = rxv_total[0];
    send(0, 48'h7FFF_8000_0001, 1'b1, 48'h0);
    check("single sclk rises", last_rises[0], 64'd48);
    check("single cs_n low cycles", last_low[0], 64'd388);
    check("single word0", {48'd0, rcv_last[0][47:32]}, 64'h7FFF);
    check("single word1", {48'd0, rcv_last[0][31:16]}, 64'h8000);
    check("single word2", {48'd0, rcv_last[0][15:0]}, 64'h0001);
    repeat (10) tick();
    check("single rx_valid pulses", rxv_total[0] - base, 64'd1);

    // Back-to-back with tx_valid held high.
    loop[0] = 1'b1;
    txd[0]  = 48'hAAAA_5555_FFFF;
    txv[0]  = 1'b1;
    wait_busy(0);
    txd[0]  = 48'h0000_0000_8001;
    wait_rx(0);
    check("b2b first rx_data", {16'd0, rxd[0]}, 64'hAAAA_5555_FFFF);
    check("b2b first decoded", {16'd0, rcv_last[0]}, 64'hAAAA_5555_FFFF);
    wait_busy(0);
    txv[0] = 1'b0;
    check("b2b cs_n high gap", last_gap[0], 64'd1);
    wait_rx(0);
    check("b2b second rx_data", {16'd0, rxd[0]}, 64'h0000_0000_8001);
    check("b2b second decoded", {16'd0, rcv_last[0]}, 64'h0000_0000_8001);
    repeat (3) tick();

    // Abort after the 20th sclk rise.
    base = rxv_total[0];
    start_frame(0, 48'h5A5A_C3C3_0F0F, 1'b1, 48'h0);
    n = 0;
    while (fr_rises[0] < 20 && n < 2000) begin
      tick();
      n++;
    end
    check("abort reached 20 rises", fr_rises[0], 64'd20);
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    check("abort cs_n", {63'd0, csn[0]}, 64'd1);
    check("abort sclk", {63'd0, sck[0]}, 64'd0);
    check("abort rx_valid", {63'd0, rxv[0]}, 64'd0);
    check("abort rx_data kept", {16'd0, rxd[0]}, 64'h0000_0000_8001);
    repeat (5) tick();
    check("abort no rx_valid", rxv_total[0] - base, 64'd0);
    send(0, 48'h1234_5678_9ABC, 1'b1, 48'h0);

    // tx_valid and tx_data activity while busy.
    base = frames[0];
    start_frame(0, 48'h0F1E_2D3C_4B5A, 1'b1, 48'h0);
    repeat (30) tick();
    txd[0] = 48'hFFFF_0000_FFFF;
    txv[0] = 1'b1;
    repeat (3) tick();
    txv[0] = 1'b0;
    txd[0] = 48'h1111_2222_3333;
    wait_rx(0);
    check("busy ignore rx_data", {16'd0, rxd[0]}, 64'h0F1E_2D3C_4B5A);
    check("busy ignore decoded", {16'd0, rcv_last[0]}, 64'h0F1E_2D3C_4B5A);
    repeat (40) tick();
    check("busy ignore frame count", frames[0] - base, 64'd1);

    // Randomized frames, loopback or independent sdi pattern.
    for (int k = 0; k < 4; k++) begin
      rnd  = {$urandom(), $urandom()};
      d_r  = rnd[47:0];
      rnd  = {$urandom(), $urandom()};
      p_r  = rnd[47:0];
      lp_r = 1'($urandom_range(0, 1));
      send(0, d_r, lp_r, p_r);
    end

    // Minimum divider and cs_n timing.
    rnd = {$urandom(), $urandom()};
    d_r = rnd[47:0];
    send(1, d_r, 1'b0, 48'hDEAD_BEEF_CAFE);
    check("min cs_n low cycles", last_low[1], 64'd98);
    check("min sclk period", rise_ivl[1], 64'd2);
    check("min sclk rises", last_rises[1], 64'd48);
    check("min rx_data", {16'd0, rxd[1]}, 64'hDEAD_BEEF_CAFE);
    for (int k = 0; k < 3; k++) begin
      rnd  = {$urandom(), $urandom()};
      d_r  = rnd[47:0];
      rnd  = {$urandom(), $urandom()};
      p_r  = rnd[47:0];
      lp_r = 1'($urandom_range(0, 1));
      send(1, d_r, lp_r, p_r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
